crm_div_seq: RTL and testbench

//   Single-clock sequencer upstream of the CRM clock divider. Owns the divider's rst_n and ratio input.

---
 rtl/crm_div_seq_if.sv | 31 +++
 rtl/crm_div_seq.sv | 140 ++++++++++++++
 tb/tb_crm_div_seq.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/crm_div_seq_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// crm_div_seq_if : ratio-change request/response bundle for crm_div_seq
// Rev 1.0
// -----------------------------------------------------------------------------
interface crm_div_seq_if #(
    parameter int RATIO_W = 4
);
    logic               req_valid;
    logic [RATIO_W-1:0] req_ratio;
    logic               req_ready;
    logic               done;
    logic               err;

    modport master (
        output req_valid,
        output req_ratio,
        input  req_ready,
        input  done,
        input  err
    );

    modport slave (
        input  req_valid,
        input  req_ratio,
        output req_ready,
        output done,
        output err
    );
endinterface
`default_nettype wire

// File: rtl/crm_div_seq.sv
`default_nettype none
// -----------------------------------------------------------------------------
// crm_div_seq : gate / reset / load / settle sequencer driving the CRM divider
// Rev 1.0
// -----------------------------------------------------------------------------
module crm_div_seq #(
    parameter int RATIO_W       = 4,
    parameter int DEFAULT_RATIO = 3,
    parameter int MIN_RATIO     = 2,
    parameter int GATE_CYC      = 2,
    parameter int RST_CYC       = 2,
    parameter int SETTLE_CYC    = 8
) (
    input  wire logic               clk_i,
    input  wire logic               rst_n,
    input  wire logic               test_mode,
    input  wire logic               test_se,
    crm_div_seq_if.slave            req_if,
    output logic                    div_rst_n,
    output logic [RATIO_W-1:0]      div_ratio,
    output logic                    gate_en
);

    localparam logic [7:0]         c_gate_cyc   = 8'(GATE_CYC);
    localparam logic [7:0]         c_rst_cyc    = 8'(RST_CYC);
    localparam logic [7:0]         c_settle_cyc = 8'(SETTLE_CYC);
    localparam logic [RATIO_W-1:0] c_def_ratio  = RATIO_W'(DEFAULT_RATIO);
    localparam logic [RATIO_W-1:0] c_min_ratio  = RATIO_W'(MIN_RATIO);

    typedef enum logic [2:0] {
        ST_INIT_RST = 3'd0,
        ST_GATE_OFF = 3'd1,
        ST_RST      = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_DONE     = 3'd4,
        ST_IDLE     = 3'd5
    } state_t;

    state_t             r_state;
    logic [7:0]         r_cnt;
    logic [RATIO_W-1:0] r_new_ratio;
    logic [RATIO_W-1:0] r_div_ratio;
    logic               r_div_rst_n;
    logic               r_gate_en;
    logic               r_done;
    logic               r_err;

    logic               w_cnt_last;
    logic               w_legal;

    // A zero count is treated as expired so a corrupted counter cannot stall.
    assign w_cnt_last = (r_cnt <= 8'd1);
    assign w_legal    = (req_if.req_ratio >= c_min_ratio);

    // The whole sequencer freezes while test_mode is high; outputs are forced below.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT_RST;
            r_cnt       <= c_rst_cyc;
            r_new_ratio <= c_def_ratio;
            r_div_ratio <= c_def_ratio;
            r_div_rst_n <= 1'b0;
            r_gate_en   <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else if (!test_mode) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_INIT_RST: begin
                    if (w_cnt_last) begin
                        r_state     <= ST_SETTLE;
                        r_cnt       <= c_settle_cyc;
                        r_div_rst_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_IDLE: begin
                    if (req_if.req_valid) begin
                        if (w_legal) begin
                            r_state     <= ST_GATE_OFF;
                            r_cnt       <= c_gate_cyc;
                            r_gate_en   <= 1'b0;
                            r_new_ratio <= req_if.req_ratio;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_GATE_OFF: begin
                    if (w_cnt_last) begin
                        r_state     <= ST_RST;
                        r_cnt       <= c_rst_cyc;
                        r_div_rst_n <= 1'b0;
                        r_div_ratio <= r_new_ratio;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_RST: begin
                    if (w_cnt_last) begin
                        r_state     <= ST_SETTLE;
                        r_cnt       <= c_settle_cyc;
                        r_div_rst_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_SETTLE: begin
                    if (w_cnt_last) begin
                        r_state   <= ST_DONE;
                        r_gate_en <= 1'b1;
                        r_done    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_INIT_RST;
                    r_cnt       <= c_rst_cyc;
                    r_div_rst_n <= 1'b0;
                    r_gate_en   <= 1'b0;
                end
            endcase
        end
    end

    assign req_if.req_ready = (r_state == ST_IDLE) & ~test_mode;
    assign req_if.done      = r_done & ~test_mode;
    assign req_if.err       = r_err & ~test_mode;
    assign div_rst_n        = r_div_rst_n | test_mode;
    assign div_ratio        = r_div_ratio;
    assign gate_en          = r_gate_en | test_mode | test_se;

endmodule
`default_nettype wire

// File: tb/tb_crm_div_seq.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_crm_div_seq : directed self-checking bench for crm_div_seq
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_crm_div_seq;

    logic       clk_i = 1'b0;
    logic       rst_n = 1'b1;
    logic       test_mode = 1'b0;
    logic       test_se = 1'b0;
    logic       div_rst_n;
    logic [3:0] div_ratio;
    logic       gate_en;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] cur_ratio;

    crm_div_seq_if #(.RATIO_W(4)) req_if ();

    crm_div_seq #(
        .RATIO_W(4), .DEFAULT_RATIO(3), .MIN_RATIO(2),
        .GATE_CYC(2), .RST_CYC(2), .SETTLE_CYC(8)
    ) dut (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .test_mode (test_mode),
        .test_se   (test_se),
        .req_if    (req_if),
        .div_rst_n (div_rst_n),
        .div_ratio (div_ratio),
        .gate_en   (gate_en)
    );

    always #5 clk_i = ~clk_i;

    // Observation vector: {err, gate_en, div_rst_n, div_ratio, done, req_ready}
    function automatic logic [8:0] obs();
        return {req_if.err, gate_en, div_rst_n, div_ratio, req_if.done, req_if.req_ready};
    endfunction

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        logic [8:0] exp;
        req_if.req_valid = 1'b0;
        req_if.req_ratio = 4'd0;
        #2 rst_n = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        n_cmp++;
        if (obs() !== 9'b0_0_0_0011_0_0) begin
            n_bad++;
            $display("FAIL reset_state got %b want %b", obs(), 9'b0_0_0_0011_0_0);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            exp = {1'b0, (k >= 10), (k >= 2), 4'd3, (k == 10), (k == 11)};
            n_cmp++;
            if (obs() !== exp) begin
                n_bad++;
                $display("FAIL init_seq cycle %0d got %b want %b", k, obs(), exp);
            end
        end
        cur_ratio = 4'd3;
    endtask

    task automatic test_legal_change();
        logic [3:0] ratios [4] = '{4'd5, 4'd15, 4'd2, 4'd2};
        logic [8:0] exp;
        for (int i = 0; i < 4; i++) begin
            req_if.req_valid = 1'b1;
            req_if.req_ratio = ratios[i];
            for (int k = 1; k <= 14; k++) begin
                step();
                if (k == 1) req_if.req_valid = 1'b0;
                exp = {1'b0, (k >= 13), !(k == 3 || k == 4),
                       (k >= 3) ? ratios[i] : cur_ratio, (k == 13), (k == 14)};
                n_cmp++;
                if (obs() !== exp) begin
                    n_bad++;
                    $display("FAIL change r=%0d cycle %0d got %b want %b", ratios[i], k, obs(), exp);
                end
            end
            cur_ratio = ratios[i];
        end
    endtask

    task automatic test_illegal_ratio();
        logic [3:0] ratios [2] = '{4'd1, 4'd0};
        logic [8:0] exp;
        for (int i = 0; i < 2; i++) begin
            req_if.req_valid = 1'b1;
            req_if.req_ratio = ratios[i];
            step();
            req_if.req_valid = 1'b0;
            exp = {1'b1, 1'b1, 1'b1, cur_ratio, 1'b0, 1'b1};
            n_cmp++;
            if (obs() !== exp) begin
                n_bad++;
                $display("FAIL illegal r=%0d err cycle got %b want %b", ratios[i], obs(), exp);
            end
            step();
            exp = {1'b0, 1'b1, 1'b1, cur_ratio, 1'b0, 1'b1};
            n_cmp++;
            if (obs() !== exp) begin
                n_bad++;
                $display("FAIL illegal r=%0d after got %b want %b", ratios[i], obs(), exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] got;
        req_if.req_valid = 1'b1;
        req_if.req_ratio = 4'd7;
        for (int k = 1; k <= 28; k++) begin
            step();
            got = obs();
            n_cmp++;
            if (got[0] !== (k == 14 || k == 28)) begin
                n_bad++;
                $display("FAIL b2b_ready cycle %0d got %b want %b", k, got[0], (k == 14 || k == 28));
            end
            n_cmp++;
            if (got[1] !== (k == 13 || k == 27)) begin
                n_bad++;
                $display("FAIL b2b_done cycle %0d got %b want %b", k, got[1], (k == 13 || k == 27));
            end
            if (k == 3 || k == 17) begin
                n_cmp++;
                if (div_ratio !== ((k == 3) ? 4'd7 : 4'd9) || div_rst_n !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_load cycle %0d got ratio %0d rst_n %b want ratio %0d rst_n 0",
                             k, div_ratio, div_rst_n, (k == 3) ? 7 : 9);
                end
            end
            if (k == 15) begin
                n_cmp++;
                if (gate_en !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_second_accept got gate_en %b want 0", gate_en);
                end
                req_if.req_valid = 1'b0;
            end
            if (k == 5) req_if.req_ratio = 4'd9;
        end
        cur_ratio = 4'd9;
    endtask

    task automatic test_async_reset();
        logic [8:0] exp;
        req_if.req_valid = 1'b1;
        req_if.req_ratio = 4'd5;
        step();
        req_if.req_valid = 1'b0;
        step();
        step();
        n_cmp++;
        if (div_rst_n !== 1'b0 || div_ratio !== 4'd5) begin
            n_bad++;
            $display("FAIL arst_in_rst got rst_n %b ratio %0d want 0 5", div_rst_n, div_ratio);
        end
        #2 rst_n = 1'b0;
        #1;
        exp = {1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0};
        n_cmp++;
        if (obs() !== exp) begin
            n_bad++;
            $display("FAIL arst_immediate got %b want %b", obs(), exp);
        end
        @(negedge clk_i);
        rst_n = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            exp = {1'b0, (k >= 10), (k >= 2), 4'd3, (k == 10), (k == 11)};
            n_cmp++;
            if (obs() !== exp) begin
                n_bad++;
                $display("FAIL arst_reinit cycle %0d got %b want %b", k, obs(), exp);
            end
        end
        cur_ratio = 4'd3;
    endtask

    task automatic test_scan_enable();
        logic [8:0] exp;
        req_if.req_valid = 1'b1;
        req_if.req_ratio = 4'd4;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 1) req_if.req_valid = 1'b0;
            test_se = (k == 3 || k == 6);
            #1;
            exp = {1'b0, (k >= 13 || k == 3 || k == 6), !(k == 3 || k == 4),
                   (k >= 3) ? 4'd4 : cur_ratio, (k == 13), (k == 14)};
            n_cmp++;
            if (obs() !== exp) begin
                n_bad++;
                $display("FAIL scan_en cycle %0d got %b want %b", k, obs(), exp);
            end
        end
        test_se = 1'b0;
        cur_ratio = 4'd4;
    endtask

    task automatic test_mode_freeze();
        logic [8:0] exp;
        logic       frz;
        req_if.req_valid = 1'b1;
        req_if.req_ratio = 4'd6;
        for (int k = 1; k <= 19; k++) begin
            step();
            if (k == 1) req_if.req_valid = 1'b0;
            frz = (k >= 6 && k <= 10);
            test_mode = frz;
            #1;
            if (frz)
                exp = {1'b0, 1'b1, 1'b1, 4'd6, 1'b0, 1'b0};
            else
                exp = {1'b0, (k >= 18), !(k == 3 || k == 4),
                       (k >= 3) ? 4'd6 : cur_ratio, (k == 18), (k == 19)};
            n_cmp++;
            if (obs() !== exp) begin
                n_bad++;
                $display("FAIL test_mode cycle %0d got %b want %b", k, obs(), exp);
            end
        end
        test_mode = 1'b0;
        cur_ratio = 4'd6;
    endtask

    initial begin
        test_reset();
        test_legal_change();
        test_illegal_ratio();
        test_back_to_back();
        test_async_reset();
        test_scan_enable();
        test_mode_freeze();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
